// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline widths, defaults and the IF/ID entry record.
package pipe_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [XLEN_DEF-1:0] NOP_INSTR_DEF = 32'h0;
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } if_id_entry_t;
endpackage

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry {pc, instr} FIFO between fetch and decode with flush and occupancy.
module if_id_queue
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     if_valid_i,
  output logic                     if_ready_o,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          instr_i,
  input  logic                     stall_i,
  input  logic                     mem_stall_i,
  input  logic                     flush_i,
  output logic                     id_valid_o,
  output logic [XLEN-1:0]          pc_o,
  output logic [XLEN-1:0]          instr_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  if_id_entry_t   r_mem [DEPTH];
  logic [PW-1:0]  r_wr, r_rd;
  logic [XLEN-1:0] r_last_pc;
  logic w_empty, w_full, w_enq, w_deq;
  if_id_entry_t w_head;
  always_comb begin
    w_empty = r_wr == r_rd;
    w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    w_enq   = if_valid_i & ~w_full;
    w_deq   = ~w_empty & ~(stall_i | mem_stall_i);
    w_head  = r_mem[r_rd[AW-1:0]];
  end
  // r_last_pc shadows the visible head so pc_o holds its value once the queue drains
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_last_pc <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (start_i) begin
      if (!w_empty) r_last_pc <= w_head.pc;
      if (flush_i) r_rd <= r_wr;
      else begin
        if (w_enq) begin
          r_mem[r_wr[AW-1:0]] <= '{pc: pc_i, instr: instr_i};
          r_wr <= r_wr + PW'(1);
        end
        if (w_deq) r_rd <= r_rd + PW'(1);
      end
    end
  end
  always_comb begin
    id_valid_o = ~w_empty;
    if_ready_o = ~w_full;
    pc_o       = w_empty ? r_last_pc : w_head.pc;
    instr_o    = w_empty ? NOP_INSTR : w_head.instr;
    count_o    = r_wr - r_rd;
  end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed vector table plus hand sequences for reset, flush and pointer wrap.
module tb_if_id_queue;
  logic clk_i = 0, rst_i = 0, start_i = 0, if_valid_i = 0, stall_i = 0, mem_stall_i = 0, flush_i = 0;
  logic [31:0] pc_i = 0, instr_i = 0, pc_o, instr_o;
  logic if_ready_o, id_valid_o;
  logic [2:0] count_o;
  int n_tests = 0, n_fail = 0;

  if_id_queue #(.XLEN(32), .DEPTH(4), .NOP_INSTR(32'h0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .if_valid_i(if_valid_i),
    .if_ready_o(if_ready_o), .pc_i(pc_i), .instr_i(instr_i), .stall_i(stall_i),
    .mem_stall_i(mem_stall_i), .flush_i(flush_i), .id_valid_o(id_valid_o),
    .pc_o(pc_o), .instr_o(instr_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic st, v, stl, ms, fl;
    logic [31:0] pc;
    logic idv, rdy;
    logic [31:0] epc, einstr;
    logic [2:0] cnt;
  } vec_t;

  vec_t vt[20];

  function automatic vec_t mk(logic st, logic v, logic stl, logic ms, logic fl, logic [31:0] pc,
                              logic idv, logic rdy, logic [31:0] epc, logic [31:0] einstr, logic [2:0] cnt);
    vec_t r;
    r.st = st; r.v = v; r.stl = stl; r.ms = ms; r.fl = fl; r.pc = pc;
    r.idv = idv; r.rdy = rdy; r.epc = epc; r.einstr = einstr; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(string tag, logic idv, logic rdy, logic [31:0] epc, logic [31:0] einstr, logic [2:0] cnt);
    chk({tag, ".id_valid"}, 32'(id_valid_o), 32'(idv));
    chk({tag, ".if_ready"}, 32'(if_ready_o), 32'(rdy));
    chk({tag, ".pc"}, pc_o, epc);
    chk({tag, ".instr"}, instr_o, einstr);
    chk({tag, ".count"}, 32'(count_o), 32'(cnt));
  endtask

  task automatic drive(logic st, logic v, logic stl, logic ms, logic fl, logic [31:0] pc);
    start_i = st; if_valid_i = v; stall_i = stl; mem_stall_i = ms; flush_i = fl;
    pc_i = pc; instr_i = 32'hAA00_0000 + pc;
  endtask

  initial begin
    // in-order stream, stall fill to full, full-cycle deq, flush, start_i gating
    vt[0]  = mk(1,1,0,0,0,'h00, 1,1,'h00,'hAA000000,1);
    vt[1]  = mk(1,1,0,0,0,'h04, 1,1,'h04,'hAA000004,1);
    vt[2]  = mk(1,1,0,0,0,'h08, 1,1,'h08,'hAA000008,1);
    vt[3]  = mk(1,0,0,0,0,'h0C, 0,1,'h08,'h00000000,0);
    vt[4]  = mk(1,1,1,0,0,'h10, 1,1,'h10,'hAA000010,1);
    vt[5]  = mk(1,1,1,0,0,'h14, 1,1,'h10,'hAA000010,2);
    vt[6]  = mk(1,1,1,0,0,'h18, 1,1,'h10,'hAA000010,3);
    vt[7]  = mk(1,1,1,0,0,'h1C, 1,0,'h10,'hAA000010,4);
    vt[8]  = mk(1,1,1,0,0,'h20, 1,0,'h10,'hAA000010,4);
    vt[9]  = mk(1,1,1,0,0,'h24, 1,0,'h10,'hAA000010,4);
    vt[10] = mk(1,1,0,0,0,'h28, 1,1,'h14,'hAA000014,3);
    vt[11] = mk(1,1,0,0,0,'h2C, 1,1,'h18,'hAA000018,3);
    vt[12] = mk(1,1,0,0,1,'h30, 0,1,'h18,'h00000000,0);
    vt[13] = mk(1,0,0,0,0,'h34, 0,1,'h18,'h00000000,0);
    vt[14] = mk(1,1,0,1,0,'h40, 1,1,'h40,'hAA000040,1);
    vt[15] = mk(0,1,0,1,0,'h44, 1,1,'h40,'hAA000040,1);
    vt[16] = mk(1,1,0,1,0,'h48, 1,1,'h40,'hAA000040,2);
    vt[17] = mk(0,1,0,1,1,'h4C, 1,1,'h40,'hAA000040,2);
    vt[18] = mk(1,0,0,0,0,'h00, 1,1,'h48,'hAA000048,1);
    vt[19] = mk(1,1,1,0,0,'h50, 1,1,'h48,'hAA000048,2);

    repeat (2) @(posedge clk_i);
    #1 chk_all("reset", 0, 1, 0, 0, 0);
    rst_i = 1;
    for (int i = 0; i < 20; i++) begin
      drive(vt[i].st, vt[i].v, vt[i].stl, vt[i].ms, vt[i].fl, vt[i].pc);
      @(posedge clk_i);
      #1 chk_all($sformatf("vec%0d", i), vt[i].idv, vt[i].rdy, vt[i].epc, vt[i].einstr, vt[i].cnt);
    end

    // asynchronous reset between edges with two entries queued
    drive(1, 0, 1, 0, 0, 0);
    #3 rst_i = 0;
    #1 chk_all("async_rst", 0, 1, 0, 0, 0);
    #1 rst_i = 1;
    @(posedge clk_i);
    #1 chk_all("post_rst", 0, 1, 0, 0, 0);

    // two-deep stream long enough to wrap the pointers more than twice
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 1, 0, 0, 32'h100 + 32'(4 * i));
      @(posedge clk_i);
      #1;
    end
    chk("wrap_fill.count", 32'(count_o), 2);
    for (int i = 2; i < 22; i++) begin
      drive(1, 1, 0, 0, 0, 32'h100 + 32'(4 * i));
      @(posedge clk_i);
      #1 chk($sformatf("wrap%0d.pc", i), pc_o, 32'h100 + 32'(4 * (i - 1)));
      chk($sformatf("wrap%0d.instr", i), instr_o, 32'hAA00_0100 + 32'(4 * (i - 1)));
      chk($sformatf("wrap%0d.count", i), 32'(count_o), 2);
    end
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk_i);
    #1 chk_all("drain1", 1, 1, 32'h154, 32'hAA00_0154, 1);
    @(posedge clk_i);
    #1 chk_all("drain2", 0, 1, 32'h154, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
